// File: rtl/fpga_synth_key_pkg.sv
// Shared constants and helpers for the key conditioning path.
package fpga_synth_key_pkg;

   localparam int KEY_DB_CYCLES_DEFAULT  = 1000000;
   localparam int KEY_ACTIVE_LOW_DEFAULT = 1;

   typedef enum logic {
      DB_STABLE  = 1'b0,
      DB_QUALIFY = 1'b1
   } db_state_t;

   function automatic int db_cnt_width(input int cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One key channel: two-flop synchroniser, polarity normalisation,
// stability counter and registered press/release strobes.
module key_debounce_cell
   import fpga_synth_key_pkg::*;
#(
   parameter int DB_CYCLES  = KEY_DB_CYCLES_DEFAULT,
   parameter int ACTIVE_LOW = KEY_ACTIVE_LOW_DEFAULT
) (
   input  logic clk,
   input  logic reset_n,
   input  logic key_raw,
   output logic key_level,
   output logic key_press,
   output logic key_release
);

   localparam int             CW       = db_cnt_width(DB_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);
   localparam logic           RAW_IDLE = (ACTIVE_LOW != 0);

   logic          s1;
   logic          s2;
   logic          p;
   db_state_t     state_q;
   db_state_t     state_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          level_d;
   logic          press_d;
   logic          release_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1          <= RAW_IDLE;
         s2          <= RAW_IDLE;
         state_q     <= DB_STABLE;
         cnt_q       <= '0;
         key_level   <= 1'b0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
      end else begin
         s1          <= key_raw;
         s2          <= s1;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         key_level   <= level_d;
         key_press   <= press_d;
         key_release <= release_d;
      end
   end

   // In STABLE the counter is always zero, so the accept test also covers DB_CYCLES == 1.
   always_comb begin
      p         = (ACTIVE_LOW != 0) ? ~s2 : s2;
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = key_level;
      press_d   = 1'b0;
      release_d = 1'b0;
      unique case (state_q)
         DB_STABLE: begin
            if (p != key_level) begin
               if (cnt_q == CNT_LAST) begin
                  level_d   = p;
                  cnt_d     = '0;
                  press_d   = p;
                  release_d = ~p;
               end else begin
                  cnt_d   = cnt_q + 1'b1;
                  state_d = DB_QUALIFY;
               end
            end
         end
         DB_QUALIFY: begin
            if (p == key_level) begin
               cnt_d   = '0;
               state_d = DB_STABLE;
            end else if (cnt_q == CNT_LAST) begin
               level_d   = p;
               cnt_d     = '0;
               press_d   = p;
               release_d = ~p;
               state_d   = DB_STABLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase
   end

endmodule

// File: rtl/key_debounce_sync.sv
// Conditions the raw pushbuttons: one independent debounce cell per key.
module key_debounce_sync
   import fpga_synth_key_pkg::*;
#(
   parameter int NUM_KEYS   = 2,
   parameter int DB_CYCLES  = KEY_DB_CYCLES_DEFAULT,
   parameter int ACTIVE_LOW = KEY_ACTIVE_LOW_DEFAULT
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NUM_KEYS-1:0] key_raw,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release
);

   if (NUM_KEYS < 1 || DB_CYCLES < 1) begin : g_param_check
      $error("key_debounce_sync: NUM_KEYS and DB_CYCLES must both be >= 1");
   end

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debounce_cell #(
         .DB_CYCLES  (DB_CYCLES),
         .ACTIVE_LOW (ACTIVE_LOW)
      ) u_cell (
         .clk         (clk),
         .reset_n     (reset_n),
         .key_raw     (key_raw[i]),
         .key_level   (key_level[i]),
         .key_press   (key_press[i]),
         .key_release (key_release[i])
      );
   end

endmodule

// File: tb/tb_key_debounce_sync.sv
// Scoreboard bench: a window-based model predicts strobes and levels; a monitor checks them.
module tb_key_debounce_sync;

   localparam int NK = 2;
   localparam int DB = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [NK-1:0] key_raw = '1;
   logic [NK-1:0] key_level;
   logic [NK-1:0] key_press;
   logic [NK-1:0] key_release;

   key_debounce_sync #(
      .NUM_KEYS   (NK),
      .DB_CYCLES  (DB),
      .ACTIVE_LOW (1)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .key_raw     (key_raw),
      .key_level   (key_level),
      .key_press   (key_press),
      .key_release (key_release)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int key;
      bit press;
   } ev_t;

   ev_t exp_q[$];
   int  n_checks = 0;
   int  n_pass   = 0;
   int  edge_n   = 0;
   int  dut_press_cnt[NK];
   int  dut_release_cnt[NK];

   // Reference model: raw samples pass a 2-deep delay line; a key's level flips once
   // the last DB pressed-samples since its previous flip all disagree with it.
   bit  m_lvl[NK];
   bit  m_dly[NK][$];
   bit  m_win[NK][$];

   task automatic check(input bit ok, input string name, input int act, input int req);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, req, edge_n);
   endtask

   task automatic model_reset();
      for (int k = 0; k < NK; k++) begin
         m_lvl[k] = 1'b0;
         m_dly[k].delete();
         m_dly[k].push_back(1'b1);
         m_dly[k].push_back(1'b1);
         m_win[k].delete();
      end
   endtask

   task automatic model_step();
      bit p;
      bit all_diff;
      ev_t e;
      edge_n++;
      if (!reset_n) begin
         model_reset();
         return;
      end
      for (int k = 0; k < NK; k++) begin
         p = ~m_dly[k].pop_front();
         m_dly[k].push_back(key_raw[k]);
         m_win[k].push_back(p);
         if (m_win[k].size() > DB) void'(m_win[k].pop_front());
         if (m_win[k].size() == DB) begin
            all_diff = 1'b1;
            foreach (m_win[k][j]) if (m_win[k][j] == m_lvl[k]) all_diff = 1'b0;
            if (all_diff) begin
               m_lvl[k] = ~m_lvl[k];
               e.cyc = edge_n;
               e.key = k;
               e.press = m_lvl[k];
               exp_q.push_back(e);
               m_win[k].delete();
            end
         end
      end
   endtask

   task automatic drive(input logic [NK-1:0] v, input int n);
      repeat (n) begin
         @(negedge clk);
         key_raw = v;
         @(posedge clk);
         model_step();
      end
   endtask

   task automatic clear_counts();
      for (int k = 0; k < NK; k++) begin
         dut_press_cnt[k]   = 0;
         dut_release_cnt[k] = 0;
      end
   endtask

   // Monitor: samples 1 time unit after each rising edge.
   initial begin
      ev_t e;
      forever begin
         @(posedge clk);
         #1;
         for (int k = 0; k < NK; k++) begin
            check(key_level[k] == m_lvl[k], $sformatf("level[%0d]", k), key_level[k], m_lvl[k]);
            if (key_press[k] || key_release[k]) begin
               check(!(key_press[k] && key_release[k]), $sformatf("press_and_release[%0d]", k), 1, 0);
               if (key_press[k]) dut_press_cnt[k]++;
               if (key_release[k]) dut_release_cnt[k]++;
               if (exp_q.size() == 0) begin
                  check(1'b0, $sformatf("unexpected_strobe[%0d]", k), {key_press[k], key_release[k]}, 0);
               end else begin
                  e = exp_q.pop_front();
                  check(e.key == k, "strobe_key", k, e.key);
                  check(e.press == key_press[k], $sformatf("strobe_kind[%0d]", k), key_press[k], e.press);
                  check(e.cyc == edge_n, $sformatf("strobe_edge[%0d]", k), edge_n, e.cyc);
               end
            end
         end
         while (exp_q.size() > 0 && exp_q[0].cyc <= edge_n) begin
            e = exp_q.pop_front();
            check(1'b0, $sformatf("missed_strobe[%0d]", e.key), edge_n, e.cyc);
         end
      end
   end

   initial begin
      model_reset();
      clear_counts();
      drive('1, 3);
      check(key_level == '0 && key_press == '0 && key_release == '0, "reset_outputs",
            {key_level, key_press, key_release}, 0);
      @(negedge clk);
      reset_n = 1'b1;

      // Clean press and release on key 0
      drive(2'b11, 5);
      clear_counts();
      drive(2'b10, 10);
      check(dut_press_cnt[0] == 1, "clean_press_cnt0", dut_press_cnt[0], 1);
      check(dut_press_cnt[1] == 0, "clean_press_cnt1", dut_press_cnt[1], 0);
      drive(2'b11, 10);

      // Bounce rejection then a clean hold
      clear_counts();
      repeat (5) begin
         drive(2'b10, 3);
         drive(2'b11, 1);
      end
      check(dut_press_cnt[0] == 0, "bounce_press_cnt", dut_press_cnt[0], 0);
      drive(2'b10, 10);
      check(dut_press_cnt[0] == 1, "bounce_hold_press_cnt", dut_press_cnt[0], 1);
      drive(2'b11, 10);

      // Release on key 1
      drive(2'b01, 10);
      clear_counts();
      drive(2'b11, 10);
      check(dut_release_cnt[1] == 1, "release_cnt1", dut_release_cnt[1], 1);
      check(key_level[1] == 1'b0, "release_level1", key_level[1], 0);

      // Simultaneous press
      clear_counts();
      drive(2'b00, 10);
      check(dut_press_cnt[0] == 1 && dut_press_cnt[1] == 1, "simul_press_cnt",
            dut_press_cnt[0] + dut_press_cnt[1], 2);
      drive(2'b11, 10);

      // Reset mid-qualification, with key 1 already accepted
      drive(2'b01, 10);
      drive(2'b00, 3);
      @(negedge clk);
      reset_n = 1'b0;
      model_reset();
      #1;
      check(key_level == '0 && key_press == '0 && key_release == '0, "async_reset_outputs",
            {key_level, key_press, key_release}, 0);
      drive(2'b00, 2);
      #2;
      reset_n = 1'b1;
      clear_counts();
      drive(2'b00, 10);
      check(dut_press_cnt[0] == 1 && dut_press_cnt[1] == 1, "post_reset_press_cnt",
            dut_press_cnt[0] + dut_press_cnt[1], 2);
      drive(2'b11, 10);

      // Long hold
      clear_counts();
      drive(2'b10, 1000);
      check(dut_press_cnt[0] == 1, "long_hold_press_cnt", dut_press_cnt[0], 1);
      check(dut_release_cnt[0] == 0, "long_hold_release_cnt", dut_release_cnt[0], 0);
      drive(2'b11, 10);

      // Randomised bursts
      for (int i = 0; i < 400; i++)
         drive(NK'($urandom_range(0, 3)), $urandom_range(1, 8));

      drive(2'b11, 12);
      check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
